lsu_mmio: RTL and testbench
===========================

LSU_MMIO -- requirements
Module: lsu_mmio

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving the data RAM word-address bits (2^ADDR_WIDTH 32-bit words).
REQ-002 The block SHALL have parameter UART_BASE, default 32'h0000_0400, giving the byte address of the UART register window.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, giving TX FIFO entries; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clocks per UART bit; it SHALL be at least 2.
REQ-005 Port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port MemWrite, input, 2 bits: store size; 00 none, 01 byte, 10 half, 11 word.
REQ-008 Port MemRead, input, 1 bit: load request.
REQ-009 Port LoadCtrl, input, 3 bits: load type per RV32I funct3; 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; other codes are treated as lw.
REQ-010 Port ADDR, input, 32 bits: byte address, equal to ALUResult.
REQ-011 Port WD, input, 32 bits: store data; the byte and half sizes use the low lanes.
REQ-012 Port RD, output, 32 bits: extended load data, combinational.
REQ-013 Port Stall, output, 1 bit: combinational request to hold the PC and suppress the register-file write.
REQ-014 Port Misaligned, output, 1 bit: combinational flag for an access that breaks size alignment.
REQ-015 Port tx, output, 1 bit: UART serial output.

Function
REQ-016 RAM region SHALL be ADDR < 4*2^ADDR_WIDTH, indexed by ADDR[ADDR_WIDTH+1:2].
- Writes are synchronous; reads are combinational (single-cycle).
REQ-017 Stores SHALL write only the addressed lanes.
- Byte: lane ADDR[1:0] gets WD[7:0].
- Half: lanes ADDR[1]*2 and +1 get WD[15:0].
- Word: all four lanes.
REQ-018 Loads SHALL select the lane(s) as in REQ-017 and then extend.
- lb/lh sign-extend; lbu/lhu zero-extend.
- RD SHALL be 0 when MemRead=0.
REQ-019 Misaligned SHALL be 1 for half with ADDR[0]=1, or word with ADDR[1:0]!=0, on a load or a store.
- When Misaligned=1, the write SHALL be suppressed and RD SHALL be 0.
REQ-020 Write to UART_BASE+0 (TXDATA, any size) SHALL push WD[7:0] into the TX FIFO when the FIFO is not full.
REQ-021 Read of UART_BASE+4 (STATUS) SHALL return the following, with the remaining bits 0:
- bit0 full; bit1 empty; bit2 tx_busy.
- bits[15:8] FIFO count, zero-extended.
REQ-022 Reads of TXDATA, and reads of any other unmapped address, SHALL return 0; writes to unmapped addresses or STATUS SHALL be ignored.
REQ-023 Stall SHALL be 1 exactly when a store targets TXDATA and the FIFO count equals FIFO_DEPTH.
- No push SHALL occur while Stall=1.
- Full SHALL be judged on the pre-edge count, so a same-cycle pop does not admit the push.
REQ-024 The FIFO SHALL keep FIFO_DEPTH entries with wrapping read and write pointers and a count of width log2(FIFO_DEPTH)+1.
- Order is first-in first-out.
REQ-025 TX FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE, FIFO not empty: pop the head into the shift register; go to START on the same edge.
- START: tx=0 for CLKS_PER_BIT clocks, then go to DATA.
- DATA: 8 bits LSB first, each CLKS_PER_BIT clocks, using a 3-bit bit index.
- STOP: tx=1 for CLKS_PER_BIT clocks, then go to IDLE.
REQ-026 tx SHALL be 1 in IDLE.
- tx_busy SHALL be 1 in any state other than IDLE.
- Back-to-back frames SHALL have at least one IDLE clock between STOP and the next START.
REQ-027 A push and a pop in the same cycle SHALL leave the count unchanged and keep both data items correct.

Reset
REQ-028 On reset=0, the block SHALL asynchronously set FSM=IDLE, tx=1, FIFO pointers and count to 0, and the baud and bit counters to 0.
REQ-029 RAM contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, with tx=1 from the reset edge, and SHALL discard all queued bytes.
REQ-031 Combinational outputs SHALL follow their inputs during reset.
- Stall=0, because the FIFO is empty.
- A STATUS read returns 32'h0000_0002.

Verification
REQ-032 Sub-word stores:
- Stimulus: word store 0x11223344 at 0x10, byte store 0xAB at 0x11, then lb, lbu and lhu at 0x10.
- Required results: lb=0x00000044, lbu=0x00000044, lhu=0x0000AB44.
- Then lb at 0x11 returns 0xFFFFFFAB.
REQ-033 Misalignment:
- Word store 0xDEADBEEF at 0x22 gives Misaligned=1, and a later lw at 0x20 returns the old value.
- lh at 0x23 gives Misaligned=1 with RD=0.
REQ-034 UART frame (CLKS_PER_BIT=4):
- Stimulus: store 0x55 to TXDATA.
- Required tx: start bit 0 for 4 clocks, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then a stop bit of 4 clocks.
- STATUS bit2=1 throughout the frame.
REQ-035 Back-pressure (FIFO_DEPTH=4):
- Stimulus: 6 consecutive TXDATA stores 0x01..0x06, with the store held while Stall=1.
- Required: Stall rises on a store once count=4; no byte is lost or duplicated; serial order is 0x01..0x06.
REQ-036 Simultaneous push and pop:
- Stimulus: push in the same cycle the FSM pops, with count=2.
- Required: count stays 2 and order is preserved.
REQ-037 Mid-frame reset:
- Stimulus: reset=0 during the DATA state with 3 bytes queued.
- Required: tx=1 immediately, and STATUS=0x00000002 after release.
- Required: no further frame is sent.

Source files
------------

// File: rtl/lsu_mmio.sv
// Load/store unit: byte-lane data RAM plus a memory-mapped UART transmitter
// (TXDATA/STATUS registers, TX FIFO, 8N1 serializer).
module lsu_mmio #(
    parameter int          ADDR_WIDTH   = 8,
    parameter logic [31:0] UART_BASE    = 32'h0000_0400,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  LoadCtrl,
    input  logic [31:0] ADDR,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        Stall,
    output logic        Misaligned,
    output logic        tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    function automatic logic breaks_align(input logic [1:0] size, input logic [1:0] lsb);
        return (size == SZ_HALF && lsb[0]) || (size == SZ_WORD && lsb != 2'b00);
    endfunction

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [7:0]            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr, rptr;
    logic [CNT_W-1:0]      count;
    state_e                state;
    logic [BAUD_W-1:0]     baud;
    logic [2:0]            bit_idx;
    logic [7:0]            shreg;

    logic [ADDR_WIDTH-1:0] widx;
    logic [31:0]           ram_word, wdata, load_val, status;
    logic [3:0]            be;
    logic [1:0]            load_size;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic                  in_ram, is_txdata, is_status, store_ok, push, pop;

    assign widx      = ADDR[ADDR_WIDTH+1:2];
    assign ram_word  = mem[widx];
    assign in_ram    = ADDR[31:ADDR_WIDTH+2] == '0;
    assign is_txdata = ADDR == UART_BASE;
    assign is_status = ADDR == UART_BASE + 32'd4;

    // Only the low two funct3 bits pick the width; every non-byte/half code acts as lw.
    assign load_size  = (LoadCtrl[1:0] == 2'b00) ? SZ_BYTE :
                        (LoadCtrl[1:0] == 2'b01) ? SZ_HALF : SZ_WORD;
    assign Misaligned = breaks_align(MemWrite, ADDR[1:0]) ||
                        (MemRead && breaks_align(load_size, ADDR[1:0]));

    assign store_ok = (MemWrite != SZ_NONE) && !Misaligned;
    assign Stall    = (MemWrite != SZ_NONE) && is_txdata && (count == FULL_CNT);
    assign push     = store_ok && is_txdata && (count != FULL_CNT);
    assign pop      = (state == IDLE) && (count != '0);

    assign status = {16'h0000, 8'(count), 5'b00000, state != IDLE, count == '0, count == FULL_CNT};
    assign lane_b = ram_word[{ADDR[1:0], 3'b000} +: 8];
    assign lane_h = ram_word[{ADDR[1], 4'b0000} +: 16];

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        be    = 4'b0000;
        wdata = WD;
        case (MemWrite)
            SZ_BYTE: begin be = 4'b0001 << ADDR[1:0]; wdata = {4{WD[7:0]}}; end
            SZ_HALF: begin be = ADDR[1] ? 4'b1100 : 4'b0011; wdata = {2{WD[15:0]}}; end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        load_val = ram_word;
        if (load_size == SZ_BYTE)
            load_val = {{24{lane_b[7] & ~LoadCtrl[2]}}, lane_b};
        else if (load_size == SZ_HALF)
            load_val = {{16{lane_h[15] & ~LoadCtrl[2]}}, lane_h};
        RD = 32'h0;
        if (MemRead && !Misaligned) begin
            if (in_ram)         RD = load_val;
            else if (is_status) RD = status;
        end
    end

    // NOTE: RAM and FIFO storage carry no reset; only pointers and counters define validity.
    always_ff @(posedge clk) begin
        if (store_ok && in_ram)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
        if (push) fifo_mem[wptr] <= WD[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // tx is registered alongside the state so each bit lasts exactly CLKS_PER_BIT clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud    <= '0;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                    if (pop) begin
                        shreg <= fifo_mem[rptr];
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        state <= DATA;
                        tx    <= shreg[0];
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mmio.sv
// Bench for lsu_mmio: load/store vector table, then UART sequences checked by a
// serial-frame monitor against a queue of expected bytes.
module tb_lsu_mmio;

    localparam int          AW    = 8;
    localparam logic [31:0] UB    = 32'h0000_0400;
    localparam int          DEPTH = 4;
    localparam int          CPB   = 4;
    localparam logic [31:0] TXD   = UB;
    localparam logic [31:0] STAT  = UB + 32'd4;

    localparam logic [1:0] SB = 2'b01, SH = 2'b10, SW = 2'b11, NS = 2'b00;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  MemWrite;
    logic        MemRead;
    logic [2:0]  LoadCtrl;
    logic [31:0] ADDR, WD, RD;
    logic        Stall, Misaligned, tx;

    lsu_mmio #(.ADDR_WIDTH(AW), .UART_BASE(UB), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead), .LoadCtrl(LoadCtrl),
        .ADDR(ADDR), .WD(WD), .RD(RD), .Stall(Stall), .Misaligned(Misaligned), .tx(tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mw;
        logic        mr;
        logic [2:0]  lc;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        mis;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         frames_rx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] mw, input logic mr, input logic [2:0] lc,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                       input logic mis);
        vec_t v;
        v = '{mw: mw, mr: mr, lc: lc, addr: a, wd: d, rd: rd, mis: mis};
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs just after the falling edge; the next rising edge commits them.
    task automatic step(input logic [1:0] mw, input logic mr, input logic [2:0] lc,
                        input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite = mw; MemRead = mr; LoadCtrl = lc; ADDR = a; WD = d;
        #1;
    endtask

    task automatic idle_step();
        step(NS, 1'b0, LW, 32'h0, 32'h0);
    endtask

    task automatic read_status();
        step(NS, 1'b1, LW, STAT, 32'h0);
    endtask

    task automatic push_byte(input logic [7:0] b, output int stalls);
        stalls = 0;
        step(SB, 1'b0, LW, TXD, {24'h0, b});
        while (Stall === 1'b1 && stalls < 300) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (Stall !== 1'b0) check("stall_release", 32'(Stall), 32'h0);
        exp_q.push_back(b);
    endtask

    task automatic quiesce();
        int n;
        n = 0;
        read_status();
        while (RD !== 32'h2 && n < 1000) begin
            read_status();
            n++;
        end
        if (RD !== 32'h2) check("quiesce_status", RD, 32'h2);
    endtask

    // Serial monitor: decodes 8N1 frames sampled on falling edges and scores them.
    initial begin : monitor
        logic [7:0] b;
        logic       shape_ok, aborted, v;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                b = 8'h00; shape_ok = 1'b1; aborted = 1'b0;
                for (int i = 1; i < 10 * CPB; i++) begin
                    @(negedge clk);
                    if (reset !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    v = tx;
                    if (i < CPB) begin
                        if (v !== 1'b0) shape_ok = 1'b0;
                    end else if (i >= 9 * CPB) begin
                        if (v !== 1'b1) shape_ok = 1'b0;
                    end else if (i % CPB == 0) begin
                        b[i / CPB - 1] = v;
                    end else if (v !== b[i / CPB - 1]) begin
                        shape_ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    frames_rx++;
                    check("frame_shape", 32'(shape_ok), 32'h1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got byte 0x%02h, expected no frame", b);
                    end else begin
                        check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
                    end
                    @(negedge clk);
                    if (reset === 1'b1) check("idle_gap_tx", 32'(tx), 32'h1);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int st[7];
        int sum;
        logic busy_all, tx_high;

        MemWrite = NS; MemRead = 1'b0; LoadCtrl = LW; ADDR = 32'h0; WD = 32'h0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_tx", 32'(tx), 32'h1);
        MemWrite = SB; ADDR = TXD; WD = 32'h99;
        #1;
        check("reset_stall", 32'(Stall), 32'h0);
        MemWrite = NS; MemRead = 1'b1; ADDR = STAT;
        #1;
        check("reset_status", RD, 32'h2);
        MemRead = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        add(SW, 0, LW,  32'h010, 32'h11223344, 32'h0,        0);
        add(SB, 0, LW,  32'h011, 32'h000000AB, 32'h0,        0);
        add(NS, 1, LB,  32'h010, 32'h0,        32'h00000044, 0);
        add(NS, 1, LBU, 32'h010, 32'h0,        32'h00000044, 0);
        add(NS, 1, LHU, 32'h010, 32'h0,        32'h0000AB44, 0);
        add(NS, 1, LB,  32'h011, 32'h0,        32'hFFFFFFAB, 0);
        add(NS, 1, LH,  32'h010, 32'h0,        32'hFFFFAB44, 0);
        add(NS, 1, LW,  32'h010, 32'h0,        32'h1122AB44, 0);
        add(SW, 0, LW,  32'h020, 32'hCAFEF00D, 32'h0,        0);
        add(SW, 0, LW,  32'h022, 32'hDEADBEEF, 32'h0,        1);
        add(NS, 1, LW,  32'h020, 32'h0,        32'hCAFEF00D, 0);
        add(NS, 1, LH,  32'h023, 32'h0,        32'h0,        1);
        add(SH, 0, LW,  32'h012, 32'h1234BEEF, 32'h0,        0);
        add(NS, 1, LHU, 32'h012, 32'h0,        32'h0000BEEF, 0);
        add(NS, 1, LH,  32'h012, 32'h0,        32'hFFFFBEEF, 0);
        add(NS, 1, 3'b011, 32'h010, 32'h0,     32'hBEEFAB44, 0);
        add(NS, 0, LW,  32'h010, 32'h0,        32'h0,        0);
        add(SH, 0, LW,  32'h011, 32'h0000FFFF, 32'h0,        1);
        add(NS, 1, LW,  32'h010, 32'h0,        32'hBEEFAB44, 0);
        add(NS, 1, LW,  32'h012, 32'h0,        32'h0,        1);
        add(SB, 0, LW,  32'h013, 32'h00000077, 32'h0,        0);
        add(NS, 1, LBU, 32'h013, 32'h0,        32'h00000077, 0);
        add(NS, 1, LB,  32'h012, 32'h0,        32'hFFFFFFEF, 0);
        add(SW, 0, LW,  32'h3FC, 32'h12345678, 32'h0,        0);
        add(NS, 1, LW,  32'h3FC, 32'h0,        32'h12345678, 0);
        add(SW, 0, LW,  32'h000, 32'h00C0FFEE, 32'h0,        0);
        add(SW, 0, LW,  32'h800, 32'hBAD0BAD0, 32'h0,        0);
        add(NS, 1, LW,  32'h800, 32'h0,        32'h0,        0);
        add(NS, 1, LW,  32'h000, 32'h0,        32'h00C0FFEE, 0);
        add(NS, 1, LW,  TXD,     32'h0,        32'h0,        0);
        add(SW, 0, LW,  STAT,    32'h000000FF, 32'h0,        0);
        add(NS, 1, LW,  STAT,    32'h0,        32'h00000002, 0);

        foreach (vecs[i]) begin
            step(vecs[i].mw, vecs[i].mr, vecs[i].lc, vecs[i].addr, vecs[i].wd);
            check($sformatf("vec%0d_rd", i), RD, vecs[i].rd);
            check($sformatf("vec%0d_mis", i), 32'(Misaligned), 32'(vecs[i].mis));
        end

        // Single 0x55 frame: busy for the whole 10-bit frame, idle afterwards.
        quiesce();
        push_byte(8'h55, st[0]);
        read_status();
        check("status_pending", RD, 32'h0000_0100);
        busy_all = 1'b1;
        for (int i = 0; i < 10 * CPB; i++) begin
            read_status();
            if (RD[2] !== 1'b1) busy_all = 1'b0;
        end
        check("busy_during_frame", 32'(busy_all), 32'h1);
        read_status();
        check("status_after_frame", RD, 32'h0000_0002);

        // Back-pressure: the sixth store waits for the first pop plus one clock.
        quiesce();
        sum = 0;
        for (int k = 1; k <= 6; k++) begin
            push_byte(8'(k), st[k]);
            if (k <= 5) sum += st[k];
        end
        check("no_stall_before_full", 32'(sum), 32'h0);
        check("stall_cycles", 32'(st[6]), 32'd38);
        read_status();
        check("status_full", RD, 32'h0000_0405);

        // Push on the exact edge the FSM pops with two bytes queued.
        quiesce();
        push_byte(8'hA1, st[0]);
        push_byte(8'hB2, st[0]);
        read_status();
        check("pushpop_count1", RD, 32'h0000_0104);
        push_byte(8'hC3, st[0]);
        for (int i = 0; i < 38; i++) begin
            read_status();
            if (i == 0)  check("queued_two", RD, 32'h0000_0204);
            if (i == 37) check("before_pop_edge", RD, 32'h0000_0204);
        end
        push_byte(8'hD4, st[0]);
        check("pushpop_no_stall", 32'(st[0]), 32'h0);
        read_status();
        check("pushpop_count2", RD, 32'h0000_0204);

        quiesce();
        repeat (2) idle_step();
        check("frames_sent", 32'(frames_rx), 32'd11);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        // Mid-frame reset with three bytes queued behind a frame of zeros.
        push_byte(8'h00, st[0]);
        push_byte(8'h11, st[0]);
        push_byte(8'h22, st[0]);
        push_byte(8'h33, st[0]);
        read_status();
        check("queued_three", RD, 32'h0000_0304);
        repeat (5) idle_step();
        check("tx_low_in_data", 32'(tx), 32'h0);
        reset = 1'b0;
        #1;
        check("tx_abort", 32'(tx), 32'h1);
        exp_q.delete();
        MemWrite = SB; ADDR = TXD; WD = 32'h5A;
        #1;
        check("stall_in_reset", 32'(Stall), 32'h0);
        MemWrite = NS; MemRead = 1'b1; ADDR = STAT;
        #1;
        check("status_in_reset", RD, 32'h2);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        read_status();
        check("status_after_reset", RD, 32'h0000_0002);
        step(NS, 1'b1, LW, 32'h010, 32'h0);
        check("ram_kept_over_reset", RD, 32'h77EFAB44);
        tx_high = 1'b1;
        for (int i = 0; i < 12 * CPB; i++) begin
            idle_step();
            if (tx !== 1'b1) tx_high = 1'b0;
        end
        check("no_frame_after_reset", 32'(tx_high), 32'h1);
        check("frames_after_reset", 32'(frames_rx), 32'd11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
